// File: rtl/tmds_encoder_multi_if.sv
// Bus bundle between the HDMI pixel pipeline and the multi-lane TMDS encoder.
interface tmds_encoder_multi_if #(
  parameter int unsigned NUM_CH = 3
);
  logic [1:0]          mode_in;
  logic [8*NUM_CH-1:0] data_in;
  logic [2*NUM_CH-1:0] control_in;
  logic [4*NUM_CH-1:0] terc4_in;
  logic [10*NUM_CH-1:0] tmds_out;
  logic [5*NUM_CH-1:0]  disparity_out;

  // Source of pixel/control data
  modport master (
    output mode_in, data_in, control_in, terc4_in,
    input  tmds_out, disparity_out
  );

  // Encoder side
  modport slave (
    input  mode_in, data_in, control_in, terc4_in,
    output tmds_out, disparity_out
  );
endinterface

// File: rtl/tmds_encoder_multi.sv
// Multi-lane TMDS encoder: control, 8b/10b video, TERC4 and guard-band symbols,
// all lanes in lockstep, with an optional register stage after q_m generation.
module tmds_encoder_multi #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned PIPE_STAGES = 1
) (
  input logic clk_in,
  input logic rst_in,
  tmds_encoder_multi_if.slave bus
);

  localparam int unsigned SYM_W = 10;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned QM_W  = 9;

  typedef enum logic [1:0] {
    MODE_CTRL  = 2'b00,
    MODE_VIDEO = 2'b01,
    MODE_TERC4 = 2'b10,
    MODE_GUARD = 2'b11
  } mode_e;

  typedef logic signed [CNT_W-1:0] cnt_t;

  generate
    if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_pipe
      $error("tmds_encoder_multi: PIPE_STAGES must be 1 or 2");
    end
  endgenerate

  // Transition-minimising stage: XOR or XNOR chain, q_m[8] records which one
  function automatic logic [QM_W-1:0] gen_qm(input logic [7:0] d);
    logic [3:0]      n1;
    logic            use_xnor;
    logic [QM_W-1:0] q;
    n1       = 4'($countones(d));
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int b = 1; b < 8; b++) begin
      q[b] = use_xnor ? ~(q[b-1] ^ d[b]) : (q[b-1] ^ d[b]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  // DC-balancing stage; sign-bit match stands in for (cnt>0,N1>N0)/(cnt<0,N0>N1)
  function automatic void video_enc(
    input  logic [QM_W-1:0] qm,
    input  cnt_t            cnt,
    output logic [SYM_W-1:0] sym,
    output cnt_t            cnt_nxt
  );
    cnt_t n1;
    cnt_t diff;
    n1   = cnt_t'($countones(qm[7:0]));
    diff = n1 + n1 - cnt_t'(8);
    if (cnt == cnt_t'(0) || diff == cnt_t'(0)) begin
      sym     = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      cnt_nxt = qm[8] ? (cnt + diff) : (cnt - diff);
    end else if (cnt[CNT_W-1] == diff[CNT_W-1]) begin
      sym     = {1'b1, qm[8], ~qm[7:0]};
      cnt_nxt = cnt + (qm[8] ? cnt_t'(2) : cnt_t'(0)) - diff;
    end else begin
      sym     = {1'b0, qm[8], qm[7:0]};
      cnt_nxt = cnt + diff - (qm[8] ? cnt_t'(0) : cnt_t'(2));
    end
  endfunction

  function automatic logic [SYM_W-1:0] ctrl_sym(input logic [1:0] c);
    logic [SYM_W-1:0] s;
    unique case (c)
      2'b00:   s = 10'b1101010100;
      2'b01:   s = 10'b0010101011;
      2'b10:   s = 10'b0101010100;
      default: s = 10'b1010101011;
    endcase
    return s;
  endfunction

  function automatic logic [SYM_W-1:0] terc4_sym(input logic [3:0] t);
    logic [SYM_W-1:0] s;
    unique case (t)
      4'd0:    s = 10'b1010011100;
      4'd1:    s = 10'b1001100011;
      4'd2:    s = 10'b1011100100;
      4'd3:    s = 10'b1011100010;
      4'd4:    s = 10'b0101110001;
      4'd5:    s = 10'b0100011110;
      4'd6:    s = 10'b0110001110;
      4'd7:    s = 10'b0100111100;
      4'd8:    s = 10'b1011001100;
      4'd9:    s = 10'b0100111001;
      4'd10:   s = 10'b0110011100;
      4'd11:   s = 10'b1011000110;
      4'd12:   s = 10'b1010001110;
      4'd13:   s = 10'b1001110001;
      4'd14:   s = 10'b0101100011;
      default: s = 10'b1011000011;
    endcase
    return s;
  endfunction

  logic [QM_W*NUM_CH-1:0]  qm_c;
  logic [QM_W*NUM_CH-1:0]  p_qm;
  mode_e                   p_mode;
  logic [2*NUM_CH-1:0]     p_ctrl;
  logic [4*NUM_CH-1:0]     p_terc4;
  logic [SYM_W*NUM_CH-1:0] tmds_c;
  logic [CNT_W*NUM_CH-1:0] cnt_nxt_c;
  logic [SYM_W*NUM_CH-1:0] tmds_q;
  logic [CNT_W*NUM_CH-1:0] cnt_q;

  // q_m for every lane straight from the input bytes
  always_comb begin
    qm_c = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      qm_c[i*QM_W +: QM_W] = gen_qm(bus.data_in[i*8 +: 8]);
    end
  end

  generate
    if (PIPE_STAGES == 2) begin : g_pipe2
      // Mid stage: q_m and the side-band controls move together to keep lanes aligned
      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          p_qm    <= '0;
          p_mode  <= MODE_CTRL;
          p_ctrl  <= '0;
          p_terc4 <= '0;
        end else begin
          p_qm    <= qm_c;
          p_mode  <= mode_e'(bus.mode_in);
          p_ctrl  <= bus.control_in;
          p_terc4 <= bus.terc4_in;
        end
      end
    end else begin : g_pipe1
      // Single-stage: the final stage sees the inputs directly
      always_comb begin
        p_qm    = qm_c;
        p_mode  = mode_e'(bus.mode_in);
        p_ctrl  = bus.control_in;
        p_terc4 = bus.terc4_in;
      end
    end
  endgenerate

  // Final symbol selection and per-lane disparity update
  always_comb begin
    logic [SYM_W-1:0] sym;
    cnt_t             cnt_l;
    cnt_t             cnt_n;
    tmds_c    = '0;
    cnt_nxt_c = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      sym   = '0;
      cnt_n = '0;
      cnt_l = cnt_t'(cnt_q[i*CNT_W +: CNT_W]);
      unique case (p_mode)
        MODE_VIDEO: video_enc(p_qm[i*QM_W +: QM_W], cnt_l, sym, cnt_n);
        MODE_CTRL:  sym = ctrl_sym(p_ctrl[i*2 +: 2]);
        MODE_TERC4: sym = terc4_sym(p_terc4[i*4 +: 4]);
        default:    sym = ((i % 3) == 1) ? 10'b0100110011 : 10'b1011001100;
      endcase
      tmds_c[i*SYM_W +: SYM_W]    = sym;
      cnt_nxt_c[i*CNT_W +: CNT_W] = cnt_n;
    end
  end

  // Output symbol and running-disparity registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tmds_q <= '0;
      cnt_q  <= '0;
    end else begin
      tmds_q <= tmds_c;
      cnt_q  <= cnt_nxt_c;
    end
  end

  assign bus.tmds_out      = tmds_q;
  assign bus.disparity_out = cnt_q;

endmodule

// File: doc/tmds_encoder_multi.md
Name: tmds_encoder_multi

Overview:
- Parametrised multi-channel TMDS/HDMI symbol encoder. It replaces the per-colour single-channel encoders in the HDMI output path.
- Encodes NUM_CH lanes in lockstep in one of four modes: control, video (8b/10b DC-balanced), TERC4 data island, or video guard band.
- Optional 2-stage pipeline for timing closure.
- Exposes per-lane running disparity so verification can observe it.

Parameters:
- NUM_CH, 3: number of lanes. Lane i uses slice i of every packed bus.
- PIPE_STAGES, 1: 1 or 2 register stages from input to tmds_out. Any other value is a $error at elaboration.

Ports:
- clk_in  input  1  pixel clock.
- rst_in  input  1  asynchronous active-high reset.
- mode_in  input  2  00 control, 01 video, 10 TERC4, 11 guard band. Common to all lanes.
- data_in  input  8*NUM_CH  video byte per lane.
- control_in  input  2*NUM_CH  {c1,c0} per lane. Used in mode 00.
- terc4_in  input  4*NUM_CH  TERC4 nibble per lane. Used in mode 10.
- tmds_out  output  10*NUM_CH  encoded symbol per lane, registered.
- disparity_out  output  5*NUM_CH  signed running disparity per lane, registered.

Behaviour:
- Reset: while rst_in is high, and asynchronously on its assertion, all pipeline registers, tmds_out and disparity_out go to 0. The first valid symbol appears PIPE_STAGES cycles after the first post-reset input.
- Latency: PIPE_STAGES = 1 registers the final symbol only. PIPE_STAGES = 2 adds a stage after q_m generation. mode_in, control_in and terc4_in are delayed alongside q_m so every lane stays aligned.
- q_m generation (per lane): N1d = popcount(data).
  - If N1d > 4, or (N1d == 4 and d[0] == 0): XNOR chain, q_m[8] = 0.
  - Otherwise: XOR chain, q_m[8] = 1.
  - q_m[0] = d[0]; q_m[i] = q_m[i-1] op d[i].
- Video, per lane, with cnt = 5-bit signed disparity and N1/N0 = ones/zeros of q_m[7:0]:
  - If cnt == 0 or N1 == N0: out = {~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}. cnt += q_m8 ? (N1 - N0) : (N0 - N1).
  - Else if (cnt > 0 and N1 > N0) or (cnt < 0 and N0 > N1): out = {1, q_m8, ~q_m[7:0]}. cnt += 2*q_m8 + N0 - N1.
  - Else: out = {0, q_m8, q_m[7:0]}. cnt += N1 - N0 - 2*(~q_m8).
  - All arithmetic is two's complement, 5 bits. The magnitude never exceeds 10, so wrap cannot occur.
- Control (00): {c1,c0}
  - 00 → 1101010100
  - 01 → 0010101011
  - 10 → 0101010100
  - 11 → 1010101011
- TERC4 (10), nibble 0..15:
  - 0–3: 1010011100, 1001100011, 1011100100, 1011100010
  - 4–7: 0101110001, 0100011110, 0110001110, 0100111100
  - 8–11: 1011001100, 0100111001, 0110011100, 1011000110
  - 12–15: 1010001110, 1001110001, 0101100011, 1011000011
- Guard band (11): lane i with i % 3 == 1 → 0100110011; all other lanes → 1011001100.
- Disparity rules:
  - Every non-video cycle reaching the final stage clears that lane's cnt to 0.
  - Lanes are fully independent.
  - A mode change takes effect on exactly the symbol whose input cycle carried the new mode_in, with no carry-over.
- Reset mid-stream: symbols and disparity in flight are discarded. After release, behaviour is identical to a cold start.

Test Plan:
- Reset, NUM_CH = 3, PIPE_STAGES = 1 → tmds_out = 0, disparity_out = 0. Assert rst_in mid-cycle → outputs clear immediately, without waiting for a clock edge.
- Mode 00, lane 0 control 00 then 11 → 1101010100 then 1010101011 one cycle later. disparity_out lane 0 = 0.
- Control cycle, then three lane-0 video bytes 0x00 → symbols 0100000000, 1111111111, 0100000000. disparity_out lane 0 = −8, +2, −6.
- Mode 10, lane 0 nibbles 0, 7, 15 → 1010011100, 0100111100, 1011000011. Mode 11 → lanes 0/1/2 = 1011001100 / 0100110011 / 1011001100.
- Lane independence: same cycle, lane 0 = 0x00 and lane 1 = 0xFF in video after control → each lane matches a single-lane golden model, and the lane-1 disparity is unaffected by lane 0.
- PIPE_STAGES = 2: repeat all of the above → identical symbol streams delayed by exactly one extra cycle. Toggling mode_in every cycle keeps per-symbol alignment.
